// File: rtl/instruction_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetcher_if
// Brief  : Icache and dispatcher handshake bundle of the instruction fetcher.
//          master = fetcher side, slave = icache/dispatcher side.
// Rev    : 1.0 - initial release
// ============================================================================
interface instruction_fetcher_if;
  // icache side
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_data;
  // dispatcher side
  logic        req_from_dispatcher;
  logic        enable_to_dispatcher;
  logic [31:0] pc_to_dispatcher;
  logic [31:0] ins_to_dispatcher;
  logic [31:0] pred_pc_to_dispatcher;
  logic        predict_jump_to_dispatcher;

  modport master (
    output icache_req, icache_addr,
    input  icache_valid, icache_data,
    input  req_from_dispatcher,
    output enable_to_dispatcher, pc_to_dispatcher, ins_to_dispatcher,
    output pred_pc_to_dispatcher, predict_jump_to_dispatcher
  );

  modport slave (
    input  icache_req, icache_addr,
    output icache_valid, icache_data,
    output req_from_dispatcher,
    input  enable_to_dispatcher, pc_to_dispatcher, ins_to_dispatcher,
    input  pred_pc_to_dispatcher, predict_jump_to_dispatcher
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module : instruction_fetcher
// Brief  : Fetches one instruction at a time from the icache, predicts the
//          next PC statically (JAL taken, backward branch taken), buffers the
//          entries in a queue and hands one entry per dispatcher request.
//          A mispredict flushes the queue and redirects fetch.
// Rev    : 1.0 - initial release
// ============================================================================
module instruction_fetcher #(
  parameter int          IQ_DEPTH = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  wire logic        clk,
  input  wire logic        rst,          // asynchronous, active low
  input  wire logic        rdy,
  input  wire logic        mispredict,
  input  wire logic [31:0] correct_pc,
  instruction_fetcher_if.master bus
);

  localparam int                 c_PTR_W = $clog2(IQ_DEPTH);
  localparam int                 c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(IQ_DEPTH);
  localparam logic [6:0]         c_OP_JAL    = 7'b1101111;
  localparam logic [6:0]         c_OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             r_state;
  logic [31:0]        r_fetch_pc;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               r_served;
  logic               r_icache_req;
  logic [31:0]        r_icache_addr;
  logic               r_enable;
  logic [31:0]        r_pc_out;
  logic [31:0]        r_ins_out;
  logic [31:0]        r_pred_out;
  logic               r_jump_out;

  logic [31:0] r_q_pc   [IQ_DEPTH];
  logic [31:0] r_q_ins  [IQ_DEPTH];
  logic [31:0] r_q_pred [IQ_DEPTH];
  logic        r_q_jump [IQ_DEPTH];

  logic [31:0] w_j_imm;
  logic [31:0] w_b_imm;
  logic [31:0] w_pred_pc;
  logic        w_pred_jump;
  logic        w_push;
  logic        w_issue;
  logic        w_wr;

  // Static next-PC prediction on the word currently returned by the icache
  always_comb begin
    w_j_imm = {{11{bus.icache_data[31]}}, bus.icache_data[31], bus.icache_data[19:12],
               bus.icache_data[20], bus.icache_data[30:21], 1'b0};
    w_b_imm = {{19{bus.icache_data[31]}}, bus.icache_data[31], bus.icache_data[7],
               bus.icache_data[30:25], bus.icache_data[11:8], 1'b0};
    w_pred_pc   = r_fetch_pc + 32'd4;
    w_pred_jump = 1'b0;
    if (bus.icache_data[6:0] == c_OP_JAL) begin
      w_pred_pc   = r_fetch_pc + w_j_imm;
      w_pred_jump = 1'b1;
    end else if (bus.icache_data[6:0] == c_OP_BRANCH && bus.icache_data[31]) begin
      // imm[12] set means a backward branch, predicted taken
      w_pred_pc   = r_fetch_pc + w_b_imm;
      w_pred_jump = 1'b1;
    end
  end

  // A response lands in the queue only in WAIT on a normal (unflushed, ready) cycle
  assign w_push  = (r_state == S_WAIT) && bus.icache_valid;
  assign w_issue = bus.req_from_dispatcher && !r_served && (r_count != '0);
  assign w_wr    = w_push && rdy && !mispredict;

  // Queue storage write; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_q_pc[r_tail]   <= r_fetch_pc;
      r_q_ins[r_tail]  <= bus.icache_data;
      r_q_pred[r_tail] <= w_pred_pc;
      r_q_jump[r_tail] <= w_pred_jump;
    end
  end

  // Fetch FSM, queue pointers and dispatcher handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_served      <= 1'b0;
      r_icache_req  <= 1'b0;
      r_icache_addr <= 32'h0;
      r_enable      <= 1'b0;
      r_pc_out      <= 32'h0;
      r_ins_out     <= 32'h0;
      r_pred_out    <= 32'h0;
      r_jump_out    <= 1'b0;
    end else if (mispredict) begin
      // Flush: a response in this cycle is dropped; an outstanding one is
      // swallowed by DISCARD so it cannot be mistaken for the redirect fetch
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_fetch_pc   <= correct_pc;
      r_enable     <= 1'b0;
      r_served     <= 1'b0;
      r_icache_req <= 1'b0;
      r_state      <= (r_state == S_WAIT && !bus.icache_valid) ? S_DISCARD : S_IDLE;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (r_count < c_DEPTH) begin
            r_icache_req  <= 1'b1;
            r_icache_addr <= r_fetch_pc;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.icache_valid) begin
            r_tail       <= r_tail + 1'b1;
            r_fetch_pc   <= w_pred_pc;
            r_icache_req <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_DISCARD: begin
          r_icache_req <= 1'b0;
          if (bus.icache_valid) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_icache_req <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase

      if (w_issue) begin
        r_enable   <= 1'b1;
        r_pc_out   <= r_q_pc[r_head];
        r_ins_out  <= r_q_ins[r_head];
        r_pred_out <= r_q_pred[r_head];
        r_jump_out <= r_q_jump[r_head];
        r_head     <= r_head + 1'b1;
        r_served   <= 1'b1;
      end else begin
        r_enable <= 1'b0;
        if (!bus.req_from_dispatcher) begin
          r_served <= 1'b0;
        end
      end

      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_issue);
    end
  end

  assign bus.icache_req                 = r_icache_req;
  assign bus.icache_addr                = r_icache_addr;
  assign bus.enable_to_dispatcher       = r_enable;
  assign bus.pc_to_dispatcher           = r_pc_out;
  assign bus.ins_to_dispatcher          = r_ins_out;
  assign bus.pred_pc_to_dispatcher      = r_pred_out;
  assign bus.predict_jump_to_dispatcher = r_jump_out;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module : tb_instruction_fetcher
// Brief  : Directed self-checking bench for instruction_fetcher with a
//          zero-latency icache responder and a strobe-capturing dispatcher.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetcher;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] pred;
    logic        jump;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic        req_d;
  logic        icache_en;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        man_valid;
  logic [31:0] man_data;

  int          n_checks;
  int          n_fail;
  logic [31:0] fetch_log[$];
  ent_t        strobes[$];

  instruction_fetcher_if bus();

  assign bus.icache_valid        = resp_valid | man_valid;
  assign bus.icache_data         = man_valid ? man_data : resp_data;
  assign bus.req_from_dispatcher = req_d;

  instruction_fetcher #(.IQ_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .mispredict (mispredict),
    .correct_pc (correct_pc),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: JAL at 0x10, backward BEQ at 0x40, forward BEQ at 0x100
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h0100006F;
      32'h40:  return 32'hFE000EE3;
      32'h100: return 32'h00000463;
      default: return 32'h00000013;
    endcase
  endfunction

  // Zero-latency icache: answer any request seen at the falling edge
  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (icache_en && rst && bus.icache_req) begin
      resp_valid = 1'b1;
      resp_data  = imem(bus.icache_addr);
      if (rdy) fetch_log.push_back(bus.icache_addr);
    end
  end

  // Dispatcher side: record every entry-valid strobe
  always @(negedge clk) begin
    if (rst && bus.enable_to_dispatcher) begin
      strobes.push_back('{bus.pc_to_dispatcher, bus.ins_to_dispatcher,
                          bus.pred_pc_to_dispatcher, bus.predict_jump_to_dispatcher});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_ent(input int idx, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] pred, input logic jump);
    if (idx >= strobes.size()) begin
      chk("entry_present", strobes.size(), idx + 1);
    end else begin
      chk("entry_pc",   strobes[idx].pc,   pc);
      chk("entry_ins",  strobes[idx].ins,  ins);
      chk("entry_pred", strobes[idx].pred, pred);
      chk("entry_jump", {31'd0, strobes[idx].jump}, {31'd0, jump});
    end
  endtask

  // One dispatcher request: raise, wait for the strobe, hold one more cycle, drop
  task automatic dispatch_one();
    int n0;
    int k;
    n0    = strobes.size();
    k     = 0;
    req_d = 1'b1;
    while (strobes.size() == n0 && k < 20) begin
      tick();
      k++;
    end
    chk("strobe_count", strobes.size(), n0 + 1);
    tick();
    req_d = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    rdy        = 1'b1;
    mispredict = 1'b0;
    correct_pc = 32'h0;
    req_d      = 1'b0;
    icache_en  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    man_valid  = 1'b0;
    man_data   = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_icache_req",  {31'd0, bus.icache_req}, 32'd0);
    chk("rst_icache_addr", bus.icache_addr, 32'h0);
    chk("rst_enable",      {31'd0, bus.enable_to_dispatcher}, 32'd0);
    chk("rst_pc_out",      bus.pc_to_dispatcher, 32'h0);

    // First request after release targets RESET_PC; icache silent so FSM sits in WAIT
    rst = 1'b1;
    tick();
    chk("first_req",  {31'd0, bus.icache_req}, 32'd1);
    chk("first_addr", bus.icache_addr, 32'h0);
    tick(); tick();
    chk("wait_hold_req", {31'd0, bus.icache_req}, 32'd1);

    // Asynchronous reset mid-WAIT clears outputs before the next rising edge
    #1 rst = 1'b0;
    #1;
    chk("async_rst_req",  {31'd0, bus.icache_req}, 32'd0);
    chk("async_rst_addr", bus.icache_addr, 32'h0);
    tick();
    icache_en = 1'b1;
    rst       = 1'b1;

    // Dispatcher idle: exactly IQ_DEPTH fetches, JAL at 0x10 redirects to 0x20
    for (int i = 0; i < 40; i++) tick();
    chk("full_fetch_count", fetch_log.size(), 8);
    chk("full_req_low", {31'd0, bus.icache_req}, 32'd0);
    if (fetch_log.size() >= 8) begin
      chk("fetch_addr_2", fetch_log[2], 32'h08);
      chk("fetch_addr_4", fetch_log[4], 32'h10);
      chk("fetch_after_jal", fetch_log[5], 32'h20);
      chk("fetch_addr_7", fetch_log[7], 32'h28);
    end

    // One issue frees one slot -> exactly one new fetch
    dispatch_one();
    for (int i = 0; i < 6; i++) tick();
    chk("refill_count", fetch_log.size(), 9);
    if (fetch_log.size() >= 9) chk("refill_addr", fetch_log[8], 32'h2C);
    chk_ent(0, 32'h0, 32'h13, 32'h4, 1'b0);

    // Straight line entries then the JAL entry
    for (int i = 0; i < 4; i++) dispatch_one();
    chk_ent(1, 32'h4, 32'h13, 32'h8, 1'b0);
    chk_ent(2, 32'h8, 32'h13, 32'hC, 1'b0);
    chk_ent(4, 32'h10, 32'h0100006F, 32'h20, 1'b1);

    // Request held for 5 cycles -> exactly one strobe
    req_d = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req_d = 1'b0;
    tick();
    chk("held_req_strobes", strobes.size(), 6);
    chk_ent(5, 32'h20, 32'h13, 32'h24, 1'b0);
    dispatch_one();
    chk_ent(6, 32'h24, 32'h13, 32'h28, 1'b0);

    // Drain through 0x3C and the backward BEQ at 0x40
    for (int i = 0; i < 7; i++) dispatch_one();
    chk_ent(12, 32'h3C, 32'h13, 32'h40, 1'b0);
    chk_ent(13, 32'h40, 32'hFE000EE3, 32'h3C, 1'b1);

    // Mispredict while a fetch is outstanding in WAIT
    for (int i = 0; i < 10; i++) tick();
    icache_en = 1'b0;
    tick();
    dispatch_one();
    tick(); tick();
    chk("mp_pre_req", {31'd0, bus.icache_req}, 32'd1);
    mispredict = 1'b1;
    correct_pc = 32'h100;
    tick();
    mispredict = 1'b0;
    chk("mp_req_low", {31'd0, bus.icache_req}, 32'd0);
    chk("mp_enable_low", {31'd0, bus.enable_to_dispatcher}, 32'd0);
    req_d = 1'b1;
    tick(); tick();
    man_valid = 1'b1;
    man_data  = 32'hDEADBEEF;
    tick();
    man_valid = 1'b0;
    tick();
    chk("redirect_req",  {31'd0, bus.icache_req}, 32'd1);
    chk("redirect_addr", bus.icache_addr, 32'h100);
    tick(); tick();
    chk("mp_no_strobe", strobes.size(), 15);

    // Redirect target is a forward BEQ: not taken, pc+4
    icache_en = 1'b1;
    k = 0;
    while (strobes.size() == 15 && k < 20) begin
      tick();
      k++;
    end
    chk("mp_strobe_count", strobes.size(), 16);
    tick();
    req_d = 1'b0;
    tick();
    chk_ent(15, 32'h100, 32'h00000463, 32'h104, 1'b0);

    // rdy low freezes the handshake; release lets the pending request issue
    for (int i = 0; i < 10; i++) tick();
    rdy = 1'b0;
    tick();
    req_d = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rdy_low_no_strobe", strobes.size(), 16);
    rdy = 1'b1;
    n0 = strobes.size();
    k  = 0;
    while (strobes.size() == n0 && k < 20) begin
      tick();
      k++;
    end
    chk("rdy_high_strobe", strobes.size(), 17);
    tick();
    req_d = 1'b0;
    tick();
    chk_ent(16, 32'h104, 32'h13, 32'h108, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
- Front-end stage directly upstream of the dispatcher.
- Fetches 32-bit instructions from the icache one at a time and predicts next PC with a static rule.
- Buffers fetched entries in an instruction queue and hands exactly one entry to the dispatcher per dispatcher request.
- Flushes and redirects on ROB mispredict.

Parameters:
IQ_DEPTH, 8, instruction queue entries (power of two, >=2)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = freeze all state except reset/flush
mispredict  in  1  ROB flush pulse
correct_pc  in  32  redirect target, valid with mispredict
icache_req  out  1  fetch request, held until icache_valid
icache_addr  out  32  fetch address
icache_valid  in  1  one-cycle response strobe
icache_data  in  32  fetched instruction
req_from_dispatcher  in  1  level request (dispatcher's enable_to_if)
enable_to_dispatcher  out  1  one-cycle entry-valid strobe (dispatcher's enable_from_if)
pc_to_dispatcher  out  32  instruction PC
ins_to_dispatcher  out  32  instruction word
pred_pc_to_dispatcher  out  32  predicted next PC
predict_jump_to_dispatcher  out  1  1 = predicted redirect (taken)

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC; queue empty (head=tail=count=0); FSM=IDLE; served=0.
  - All outputs 0: icache_req, icache_addr, enable_to_dispatcher, pc/ins/pred_pc/predict_jump.
- Priority per clock edge: reset > mispredict > !rdy (hold) > normal.
- Fetch FSM, states IDLE, WAIT, DISCARD:
  - IDLE: if count<IQ_DEPTH, drive icache_req=1, icache_addr=fetch_pc, go WAIT. Else stay.
  - WAIT: hold req/addr. On icache_valid: push entry, fetch_pc<=pred_pc, icache_req<=0, go IDLE. At most one request outstanding, so count<IQ_DEPTH at issue guarantees space.
  - DISCARD: icache_req<=0. On icache_valid, drop the data and go IDLE.
- Prediction is combinational on icache_data, with pc=fetch_pc:
  - opcode 1101111 (JAL): taken; pred_pc=pc+sext(J-imm).
  - opcode 1100011 (branch): taken iff imm[12]=1 (backward); pred_pc=pc+sext(B-imm), else pc+4.
  - All others, including JALR: not taken; pred_pc=pc+4.
  - All additions are 32-bit and wrap modulo 2^32.
- Dispatcher handshake:
  - Issue when req_from_dispatcher=1, served=0, count>0 (count as seen at the edge).
  - On issue: next cycle enable_to_dispatcher=1 with the head entry's fields; pop head; served<=1.
  - enable_to_dispatcher is high for exactly one cycle, then returns to 0. Data outputs hold their last values.
  - served clears only on a cycle where req_from_dispatcher=0. The dispatcher keeps req high one cycle after the strobe, so this prevents a double issue.
  - A push and a pop in the same cycle leave count unchanged. A pop from an entry pushed that same cycle is not allowed; an empty queue at the edge means no issue.
- Mispredict (synchronous, ignores rdy):
  - Queue cleared; fetch_pc<=correct_pc; enable_to_dispatcher<=0; served<=0.
  - If FSM=WAIT and icache_valid is not asserted that cycle, go DISCARD. Otherwise go IDLE.
  - icache_req<=0.
  - A response arriving in the mispredict cycle is dropped.
- Pointers wrap modulo IQ_DEPTH. count ranges 0..IQ_DEPTH, width log2(IQ_DEPTH)+1.
- rdy=0: no state or output changes. An icache_valid arriving while rdy=0 is lost; the icache is only operated while rdy=1.

Test Plan:
- Reset: rst=0 mid-WAIT, asynchronous -> all outputs 0 immediately. After release, first icache_addr=RESET_PC.
- Straight line: icache returns 32'h00000013 at 0x0, 0x4, 0x8; dispatcher requests three times -> entries pc 0x0/0x4/0x8, pred_pc +4, predict_jump=0, one strobe per request.
- JAL: 32'h0100006F at 0x10 -> predict_jump=1, pred_pc=0x20, next icache_addr=0x20. Backward BEQ 32'hFE000EE3 at 0x40 -> pred_pc=0x3C, taken. Forward BEQ -> pc+4, not taken.
- Full queue: dispatcher idle, IQ_DEPTH=8 -> exactly 8 fetches then icache_req stays 0. One issue -> exactly one new fetch.
- Held request: req_from_dispatcher held high for 5 cycles with 3 queued entries -> exactly one strobe. Drop req, re-raise -> second strobe.
- Mispredict in WAIT, correct_pc=0x100: stale icache_valid discarded, queue empty, next icache_addr=0x100, no strobe until a new entry is queued.
